// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout monitor: FSM state encoding,
// BCD/stolen-count limits and the two-digit BCD increment helper.
package checkout_pkg;

  typedef enum logic {IDLE, ALARM} chk_state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] STOLEN_MAX    = 4'd15;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones != BCD_MAX_DIGIT) return {tens, ones + 4'd1};
    if (tens != BCD_MAX_DIGIT) return {tens + 4'd1, 4'd0};
    return 8'h00;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Raw active-low key conditioning: 2-FF synchroniser plus falling-edge detect,
// giving a single-cycle press pulse per key press.
module key_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press_p
);

  // [0],[1] synchronise; [2] holds the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[1:0], key_n};
  end

  assign press_p = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/checkout_monitor.sv
// Checkout monitor: counts scanned items in BCD, tallies stolen items and raises a
// blinking alarm on a stolen scan until the operator acknowledges it.
module checkout_monitor
  import checkout_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_n,
  input  logic       ack_n,
  input  logic       discounted,
  input  logic       stolen,
  output logic [3:0] item_tens,
  output logic [3:0] item_ones,
  output logic [3:0] stolen_cnt,
  output logic       last_discount,
  output logic       alarm,
  output logic       alarm_led
);

  localparam int unsigned CntW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CntW-1:0] BlinkMax = CntW'(BLINK_CYCLES - 1);

  logic scan_p, ack_p;

  key_edge u_scan_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (scan_n),
    .press_p (scan_p)
  );

  key_edge u_ack_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (ack_n),
    .press_p (ack_p)
  );

  chk_state_t      state_q, state_d;
  logic [3:0]      tens_q, tens_d, ones_q, ones_d;
  logic [3:0]      scnt_q, scnt_d;
  logic            ldisc_q, ldisc_d;
  logic            led_q, led_d;
  logic [CntW-1:0] blink_q, blink_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tens_q  <= '0;
      ones_q  <= '0;
      scnt_q  <= '0;
      ldisc_q <= 1'b0;
      led_q   <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      scnt_q  <= scnt_d;
      ldisc_q <= ldisc_d;
      led_q   <= led_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    scnt_d  = scnt_q;
    ldisc_d = ldisc_q;
    led_d   = led_q;
    blink_d = blink_q;
    unique case (state_q)
      IDLE: begin
        // ack is meaningless here, so a simultaneous ack never blocks a scan.
        if (scan_p) begin
          {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
          ldisc_d = discounted;
          if (stolen) begin
            if (scnt_q != STOLEN_MAX) scnt_d = scnt_q + 4'd1;
            state_d = ALARM;
            blink_d = '0;
            led_d   = 1'b1;
          end
        end
      end
      ALARM: begin
        if (ack_p) begin
          state_d = IDLE;
          blink_d = '0;
          led_d   = 1'b0;
        end else if (blink_q == BlinkMax) begin
          blink_d = '0;
          led_d   = ~led_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign item_tens     = tens_q;
  assign item_ones     = ones_q;
  assign stolen_cnt    = scnt_q;
  assign last_discount = ldisc_q;
  assign alarm         = (state_q == ALARM);
  assign alarm_led     = led_q;

endmodule

// File: tb/tb_checkout_monitor.sv
// Directed bench for checkout_monitor: a vector table for scan/ack sequences plus
// hand-written sequences for blink timing, BCD wrap, saturation, held keys and reset.
module tb_checkout_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scan_n = 1'b1;
  logic       ack_n = 1'b1;
  logic       discounted = 1'b0;
  logic       stolen = 1'b0;
  logic [3:0] item_tens, item_ones, stolen_cnt;
  logic       last_discount, alarm, alarm_led;

  int checks = 0;
  int errors = 0;

  checkout_monitor #(.BLINK_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scan_n        (scan_n),
    .ack_n         (ack_n),
    .discounted    (discounted),
    .stolen        (stolen),
    .item_tens     (item_tens),
    .item_ones     (item_ones),
    .stolen_cnt    (stolen_cnt),
    .last_discount (last_discount),
    .alarm         (alarm),
    .alarm_led     (alarm_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         s, a, st, di;
    logic [3:0] tens, ones, scnt;
    logic       ldisc, alm;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic press(input bit s, input bit a, input bit st, input bit di);
    scan_n = !s;
    ack_n = !a;
    stolen = st;
    discounted = di;
    repeat (3) tick();
    scan_n = 1'b1;
    ack_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    scan_n = 1'b1;
    ack_n = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tens"}, item_tens, 0);
    chk({nm, "_ones"}, item_ones, 0);
    chk({nm, "_scnt"}, stolen_cnt, 0);
    chk({nm, "_ldisc"}, last_discount, 0);
    chk({nm, "_alarm"}, alarm, 0);
    chk({nm, "_led"}, alarm_led, 0);
  endtask

  initial begin
    //         s  a  st di tens  ones  scnt  ldisc alm
    tbl[0] = '{1, 0, 0, 1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[1] = '{1, 0, 0, 0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0};
    tbl[2] = '{1, 0, 0, 1, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0};
    tbl[3] = '{1, 0, 1, 0, 4'd0, 4'd4, 4'd1, 1'b0, 1'b1};
    tbl[4] = '{1, 0, 0, 1, 4'd0, 4'd4, 4'd1, 1'b0, 1'b1};
    tbl[5] = '{0, 1, 0, 0, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0};
    tbl[6] = '{0, 1, 0, 1, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0};
    tbl[7] = '{1, 1, 1, 1, 4'd0, 4'd5, 4'd2, 1'b1, 1'b1};
    tbl[8] = '{1, 1, 0, 0, 4'd0, 4'd5, 4'd2, 1'b1, 1'b0};
    tbl[9] = '{1, 1, 0, 0, 4'd0, 4'd6, 4'd2, 1'b0, 1'b0};

    repeat (2) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      press(tbl[i].s, tbl[i].a, tbl[i].st, tbl[i].di);
      chk($sformatf("vec%0d_tens", i), item_tens, tbl[i].tens);
      chk($sformatf("vec%0d_ones", i), item_ones, tbl[i].ones);
      chk($sformatf("vec%0d_scnt", i), stolen_cnt, tbl[i].scnt);
      chk($sformatf("vec%0d_ldisc", i), last_discount, tbl[i].ldisc);
      chk($sformatf("vec%0d_alarm", i), alarm, tbl[i].alm);
    end

    // Alarm entry latency and blink cadence.
    do_reset();
    scan_n = 1'b0;
    stolen = 1'b1;
    repeat (2) tick();
    chk("alarm_before_edge3", alarm, 0);
    tick();
    chk("alarm_entry", alarm, 1);
    chk("led_entry", alarm_led, 1);
    for (int k = 1; k < 12; k++) begin
      tick();
      chk($sformatf("blink_k%0d", k), alarm_led, ((k / 4) % 2 == 0) ? 8'd1 : 8'd0);
    end
    scan_n = 1'b1;
    stolen = 1'b0;
    repeat (3) tick();
    ack_n = 1'b0;
    repeat (2) tick();
    chk("alarm_before_ack_edge3", alarm, 1);
    tick();
    chk("ack_alarm", alarm, 0);
    chk("ack_led", alarm_led, 0);
    chk("ack_item", item_ones, 1);
    ack_n = 1'b1;
    repeat (3) tick();

    // BCD carries and wrap, with a stolen item at 99.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      press(1, 0, (i == 100), 0);
      if (i == 9)  chk("bcd09", {item_tens, item_ones}, 8'h09);
      if (i == 10) chk("bcd10", {item_tens, item_ones}, 8'h10);
      if (i == 99) chk("bcd99", {item_tens, item_ones}, 8'h99);
    end
    chk("bcd_wrap", {item_tens, item_ones}, 8'h00);
    chk("wrap_alarm", alarm, 1);
    chk("wrap_scnt", stolen_cnt, 1);
    press(0, 1, 0, 0);
    for (int i = 2; i <= 17; i++) begin
      press(1, 0, 1, 0);
      chk($sformatf("sat_alarm%0d", i), alarm, 1);
      press(0, 1, 0, 0);
    end
    chk("sat_scnt", stolen_cnt, 15);
    chk("sat_item", {item_tens, item_ones}, 8'h16);

    // Held key and short glitch each give exactly one increment.
    scan_n = 1'b0;
    stolen = 1'b0;
    repeat (50) tick();
    scan_n = 1'b1;
    repeat (3) tick();
    chk("held_key", {item_tens, item_ones}, 8'h17);
    scan_n = 1'b0;
    tick();
    scan_n = 1'b1;
    repeat (4) tick();
    chk("glitch", {item_tens, item_ones}, 8'h18);

    // Asynchronous reset mid-alarm.
    press(1, 0, 1, 1);
    chk("pre_rst_alarm", alarm, 1);
    tick();
    #3 reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    #2 reset_n = 1'b1;
    repeat (10) tick();
    chk_all_zero("post_rst");
    press(1, 0, 0, 0);
    chk("post_rst_scan", {item_tens, item_ones}, 8'h01);
    chk("post_rst_scan_alarm", alarm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
